// File: rtl/xadc_drp_sequencer.sv
// xadc_drp_sequencer: round-robin DRP reader that issues one read per eoc across four XADC aux slots.
// Latency: den one cycle after an accepted eoc; smp_valid one cycle after drdy; next den no earlier than drdy+2.
// Backpressure: one-deep output register; a result that arrives while it is still full is dropped and counted.
// Optional feature macro XADC_SEQ_TIMEOUT_EN: abandon a read after TIMEOUT_CYCLES WAIT cycles without drdy.
module xadc_drp_sequencer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [3:0]  chan_en,
    input  logic        eoc,
    output logic        den,
    output logic        dwe,
    output logic [15:0] di,
    output logic [6:0]  daddr,
    input  logic [15:0] do_in,
    input  logic        drdy,
    output logic        smp_valid,
    input  logic        smp_ready,
    output logic [1:0]  smp_chan,
    output logic [11:0] smp_data,
    output logic [7:0]  drop_cnt,
    output logic        timeout,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t      state, state_nxt;
    logic [1:0]  last, last_nxt;
    logic [1:0]  sel, sel_nxt;
    logic        den_nxt;
    logic [6:0]  daddr_nxt;
    logic        smp_valid_nxt;
    logic [1:0]  smp_chan_nxt;
    logic [11:0] smp_data_nxt;
    logic [7:0]  drop_nxt;
    logic        timeout_nxt;
    logic        busy_nxt;
    logic        out_free;

    // The sequencer only reads; the write side of the DRP is tied off.
    assign dwe = 1'b0;
    assign di  = 16'h0000;

    // Low nibble of the DRP word is below the 12-bit ADC resolution.
    logic unused_lsb;
    assign unused_lsb = ^do_in[3:0];

    function automatic logic [6:0] slot_addr(input logic [1:0] s);
        case (s)
            2'd0:    slot_addr = 7'h1E;
            2'd1:    slot_addr = 7'h17;
            2'd2:    slot_addr = 7'h1F;
            default: slot_addr = 7'h16;
        endcase
    endfunction

    // Scan last+1 .. last+4; descending loop so the nearest enabled slot wins.
    function automatic logic [1:0] next_slot(input logic [1:0] from, input logic [3:0] en);
        logic [1:0] cand;
        next_slot = from;
        for (int i = 4; i >= 1; i--) begin
            cand = from + 2'(i);
            if (en[cand]) next_slot = cand;
        end
    endfunction

`ifdef XADC_SEQ_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] tmo_cnt, tmo_cnt_nxt;

    // WAIT-cycle counter; value k during the (k+1)th WAIT cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) tmo_cnt <= 8'd0;
        else         tmo_cnt <= tmo_cnt_nxt;
    end
`else
    logic [7:0] unused_tmo;
    assign unused_tmo = 8'(TIMEOUT_CYCLES);
`endif

    // The output register can take a new sample if empty or being drained this cycle.
    assign out_free = !smp_valid || smp_ready;

    // State and all registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            last      <= 2'd3;
            sel       <= 2'd0;
            den       <= 1'b0;
            daddr     <= 7'h1E;
            smp_valid <= 1'b0;
            smp_chan  <= 2'd0;
            smp_data  <= 12'h000;
            drop_cnt  <= 8'd0;
            timeout   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            last      <= last_nxt;
            sel       <= sel_nxt;
            den       <= den_nxt;
            daddr     <= daddr_nxt;
            smp_valid <= smp_valid_nxt;
            smp_chan  <= smp_chan_nxt;
            smp_data  <= smp_data_nxt;
            drop_cnt  <= drop_nxt;
            timeout   <= timeout_nxt;
            busy      <= busy_nxt;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_nxt     = state;
        last_nxt      = last;
        sel_nxt       = sel;
        den_nxt       = 1'b0;
        daddr_nxt     = daddr;
        smp_valid_nxt = smp_valid && !smp_ready;
        smp_chan_nxt  = smp_chan;
        smp_data_nxt  = smp_data;
        drop_nxt      = drop_cnt;
        timeout_nxt   = 1'b0;
`ifdef XADC_SEQ_TIMEOUT_EN
        tmo_cnt_nxt   = tmo_cnt;
`endif
        case (state)
            IDLE: begin
                if (eoc && (chan_en != 4'b0000)) begin
                    sel_nxt   = next_slot(last, chan_en);
                    daddr_nxt = slot_addr(sel_nxt);
                    den_nxt   = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = WAIT;
`ifdef XADC_SEQ_TIMEOUT_EN
                tmo_cnt_nxt = 8'd0;
`endif
            end
            WAIT: begin
                if (drdy) begin
                    last_nxt  = sel;
                    state_nxt = IDLE;
                    if (out_free) begin
                        smp_valid_nxt = 1'b1;
                        smp_chan_nxt  = sel;
                        smp_data_nxt  = do_in[15:4];
                    end else if (drop_cnt != 8'hFF) begin
                        drop_nxt = drop_cnt + 8'd1;
                    end
                end
`ifdef XADC_SEQ_TIMEOUT_EN
                else if (tmo_cnt == TMO_LAST) begin
                    // Skip the unresponsive slot so the rotation keeps moving.
                    timeout_nxt = 1'b1;
                    last_nxt    = sel;
                    state_nxt   = IDLE;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + 8'd1;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_xadc_drp_sequencer.sv
// tb_xadc_drp_sequencer: directed checks of slot rotation, masking, drops, eoc storms, timeout and reset.
// Inputs are driven 1 ns after the falling edge; outputs are read at the same point.
// A small DRP responder answers each den after a programmable number of WAIT cycles.
module tb_xadc_drp_sequencer;

    logic        clk = 1'b0;
    logic        resetn;
    logic [3:0]  chan_en;
    logic        eoc;
    logic        den, dwe;
    logic [15:0] di;
    logic [6:0]  daddr;
    logic [15:0] do_in;
    logic        drdy;
    logic        smp_valid, smp_ready;
    logic [1:0]  smp_chan;
    logic [11:0] smp_data;
    logic [7:0]  drop_cnt;
    logic        timeout, busy;

    int n_cmp = 0;
    int n_bad = 0;

    // responder state
    logic        rsp_en    = 1'b1;
    int          rsp_delay = 3;
    logic [15:0] rsp_data  = 16'hABC0;
    logic [6:0]  mute_addr = 7'h7F;
    logic        rsp_drdy  = 1'b0;
    logic [15:0] rsp_do    = 16'h0000;
    logic        pend      = 1'b0;
    int          cnt       = 0;
    // manual drive
    logic        man_drdy;
    logic [15:0] man_do;
    // monitors
    int den_cnt   = 0;
    int acc_cnt   = 0;
    int chan1_cnt = 0;

    assign drdy  = rsp_drdy | man_drdy;
    assign do_in = man_drdy ? man_do : rsp_do;

    xadc_drp_sequencer #(.TIMEOUT_CYCLES(10)) dut (
        .clk(clk), .resetn(resetn), .chan_en(chan_en), .eoc(eoc),
        .den(den), .dwe(dwe), .di(di), .daddr(daddr),
        .do_in(do_in), .drdy(drdy),
        .smp_valid(smp_valid), .smp_ready(smp_ready), .smp_chan(smp_chan), .smp_data(smp_data),
        .drop_cnt(drop_cnt), .timeout(timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    // DRP responder: drdy for one cycle, rsp_delay negedges after den is seen.
    always @(negedge clk) begin
        if (!resetn) begin
            pend     = 1'b0;
            rsp_drdy = 1'b0;
        end else begin
            rsp_drdy = 1'b0;
            if (pend) begin
                if (cnt == 0) begin
                    rsp_drdy = 1'b1;
                    rsp_do   = rsp_data;
                    pend     = 1'b0;
                end else begin
                    cnt = cnt - 1;
                end
            end
            if (den && rsp_en && (daddr != mute_addr)) begin
                pend = 1'b1;
                cnt  = rsp_delay - 1;
            end
        end
    end

    // Event counters for den pulses and accepted samples.
    always @(negedge clk) begin
        if (den) den_cnt++;
        if (smp_valid && smp_ready) begin
            acc_cnt++;
            if (smp_chan == 2'd1) chan1_cnt++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_eoc();
        eoc = 1'b1;
        tick();
        eoc = 1'b0;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 40 && !smp_valid; i++) tick();
    endtask

    task automatic test_reset();
        logic [49:0] exp_v;
        exp_v = {1'b0, 1'b0, 16'h0, 7'h1E, 1'b0, 2'd0, 12'h0, 8'h0, 1'b0, 1'b0};
        repeat (3) tick();
        n_cmp++;
        if ({den, dwe, di, daddr, smp_valid, smp_chan, smp_data, drop_cnt, timeout, busy} !== exp_v) begin
            n_bad++;
            $display("FAIL reset_held: got %h want %h",
                     {den, dwe, di, daddr, smp_valid, smp_chan, smp_data, drop_cnt, timeout, busy}, exp_v);
        end
        resetn = 1'b1;
        tick();
        n_cmp++;
        if ({den, dwe, di, daddr, smp_valid, smp_chan, smp_data, drop_cnt, timeout, busy} !== exp_v) begin
            n_bad++;
            $display("FAIL reset_released: got %h want %h",
                     {den, dwe, di, daddr, smp_valid, smp_chan, smp_data, drop_cnt, timeout, busy}, exp_v);
        end
    endtask

    task automatic test_round_robin();
        logic [6:0] exp_addr [5];
        exp_addr = '{7'h1E, 7'h17, 7'h1F, 7'h16, 7'h1E};
        chan_en = 4'b1111; smp_ready = 1'b1; rsp_delay = 3; rsp_data = 16'hABC0;
        for (int k = 0; k < 5; k++) begin
            pulse_eoc();
            n_cmp++;
            if (den !== 1'b1) begin n_bad++; $display("FAIL rr_den[%0d]: got %b want 1", k, den); end
            n_cmp++;
            if (daddr !== exp_addr[k]) begin n_bad++; $display("FAIL rr_daddr[%0d]: got %h want %h", k, daddr, exp_addr[k]); end
            wait_valid();
            n_cmp++;
            if (smp_valid !== 1'b1) begin n_bad++; $display("FAIL rr_valid[%0d]: got %b want 1", k, smp_valid); end
            n_cmp++;
            if (smp_chan !== 2'(k % 4)) begin n_bad++; $display("FAIL rr_chan[%0d]: got %0d want %0d", k, smp_chan, k % 4); end
            n_cmp++;
            if (smp_data !== 12'hABC) begin n_bad++; $display("FAIL rr_data[%0d]: got %h want abc", k, smp_data); end
            n_cmp++;
            if (busy !== 1'b0) begin n_bad++; $display("FAIL rr_idle[%0d]: busy got %b want 0", k, busy); end
            tick();
        end
    endtask

    task automatic test_mask();
        logic [1:0] exp_chan [4];
        int d0;
        exp_chan = '{2'd2, 2'd0, 2'd2, 2'd0};
        chan_en = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            pulse_eoc();
            n_cmp++;
            if (daddr !== ((exp_chan[k] == 2'd2) ? 7'h1F : 7'h1E)) begin
                n_bad++; $display("FAIL mask_daddr[%0d]: got %h", k, daddr);
            end
            wait_valid();
            n_cmp++;
            if (smp_chan !== exp_chan[k]) begin n_bad++; $display("FAIL mask_chan[%0d]: got %0d want %0d", k, smp_chan, exp_chan[k]); end
            tick();
        end
        chan_en = 4'b0000;
        d0 = den_cnt;
        pulse_eoc();
        repeat (5) tick();
        n_cmp++;
        if (den_cnt !== d0) begin n_bad++; $display("FAIL mask_zero_den: got %0d pulses want 0", den_cnt - d0); end
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL mask_zero_busy: got %b want 0", busy); end
    endtask

    task automatic test_eoc_storm();
        logic [13:0] den_v, busy_v;
        int a0;
        chan_en = 4'b1111; smp_ready = 1'b1; rsp_delay = 5;
        a0 = acc_cnt;
        eoc = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick();
            den_v[i]  = den;
            busy_v[i] = busy;
        end
        eoc = 1'b0;
        n_cmp++;
        if (den_v !== 14'h0081) begin n_bad++; $display("FAIL storm_den: got %b want %b", den_v, 14'h0081); end
        n_cmp++;
        if (busy_v !== 14'h1FBF) begin n_bad++; $display("FAIL storm_busy: got %b want %b", busy_v, 14'h1FBF); end
        n_cmp++;
        if (acc_cnt - a0 !== 2) begin n_bad++; $display("FAIL storm_samples: got %0d want 2", acc_cnt - a0); end
        repeat (2) tick();
    endtask

    task automatic test_drop();
        chan_en = 4'b0100; smp_ready = 1'b0; rsp_delay = 3;
        for (int r = 0; r < 300; r++) begin
            rsp_data = (r == 0) ? 16'h1230 : 16'h4560;
            pulse_eoc();
            for (int j = 0; j < 20 && busy; j++) tick();
            if (r == 2) begin
                n_cmp++;
                if (drop_cnt !== 8'd2) begin n_bad++; $display("FAIL drop_early: got %0d want 2", drop_cnt); end
            end
        end
        n_cmp++;
        if (smp_valid !== 1'b1) begin n_bad++; $display("FAIL drop_held_valid: got %b want 1", smp_valid); end
        n_cmp++;
        if (smp_data !== 12'h123) begin n_bad++; $display("FAIL drop_held_data: got %h want 123", smp_data); end
        n_cmp++;
        if (smp_chan !== 2'd2) begin n_bad++; $display("FAIL drop_held_chan: got %0d want 2", smp_chan); end
        n_cmp++;
        if (drop_cnt !== 8'd255) begin n_bad++; $display("FAIL drop_sat: got %0d want 255", drop_cnt); end
        // drdy coincident with the consumer draining the held sample
        rsp_en = 1'b0;
        pulse_eoc();
        tick();
        man_do = 16'hDEF0; man_drdy = 1'b1; smp_ready = 1'b1;
        tick();
        man_drdy = 1'b0;
        n_cmp++;
        if (smp_valid !== 1'b1) begin n_bad++; $display("FAIL simul_valid: got %b want 1", smp_valid); end
        n_cmp++;
        if (smp_data !== 12'hDEF) begin n_bad++; $display("FAIL simul_data: got %h want def", smp_data); end
        n_cmp++;
        if (drop_cnt !== 8'd255) begin n_bad++; $display("FAIL simul_drop: got %0d want 255", drop_cnt); end
        tick();
        n_cmp++;
        if (smp_valid !== 1'b0) begin n_bad++; $display("FAIL simul_drain: got %b want 0", smp_valid); end
        rsp_en = 1'b1;
    endtask

    task automatic test_timeout();
        logic [20:0] tmo_v;
        int c1;
        resetn = 1'b0; tick(); resetn = 1'b1; tick();
        chan_en = 4'b1111; smp_ready = 1'b1; rsp_delay = 3; rsp_data = 16'h7770; mute_addr = 7'h17;
        pulse_eoc();
        wait_valid();
        n_cmp++;
        if (smp_chan !== 2'd0) begin n_bad++; $display("FAIL tmo_first_chan: got %0d want 0", smp_chan); end
        tick();
        c1 = chan1_cnt;
        pulse_eoc();
        n_cmp++;
        if (daddr !== 7'h17) begin n_bad++; $display("FAIL tmo_slot1_addr: got %h want 17", daddr); end
        tmo_v = '0;
        for (int i = 2; i <= 20; i++) begin
            tick();
            tmo_v[i] = timeout;
        end
`ifdef XADC_SEQ_TIMEOUT_EN
        n_cmp++;
        if (tmo_v !== 21'h001000) begin n_bad++; $display("FAIL tmo_pulse: got %h want 001000", tmo_v); end
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL tmo_idle: got %b want 0", busy); end
        pulse_eoc();
        n_cmp++;
        if (daddr !== 7'h1F) begin n_bad++; $display("FAIL tmo_next_addr: got %h want 1f", daddr); end
        wait_valid();
        n_cmp++;
        if (smp_chan !== 2'd2) begin n_bad++; $display("FAIL tmo_next_chan: got %0d want 2", smp_chan); end
        n_cmp++;
        if (chan1_cnt !== c1) begin n_bad++; $display("FAIL tmo_no_slot1: got %0d samples want 0", chan1_cnt - c1); end
        tick();
`else
        n_cmp++;
        if (tmo_v !== 21'h0) begin n_bad++; $display("FAIL notmo_pulse: got %h want 0", tmo_v); end
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL notmo_wait: busy got %b want 1", busy); end
        n_cmp++;
        if (chan1_cnt !== c1) begin n_bad++; $display("FAIL notmo_no_slot1: got %0d samples want 0", chan1_cnt - c1); end
        resetn = 1'b0; tick(); resetn = 1'b1; tick();
`endif
        mute_addr = 7'h7F;
    endtask

    task automatic test_reset_midread();
        logic [49:0] exp_v;
        int a0;
        exp_v = {1'b0, 1'b0, 16'h0, 7'h1E, 1'b0, 2'd0, 12'h0, 8'h0, 1'b0, 1'b0};
        chan_en = 4'b1111; smp_ready = 1'b1; rsp_en = 1'b0;
        pulse_eoc();
        tick();
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy: got %b want 1", busy); end
        resetn = 1'b0;
        #1;
        n_cmp++;
        if ({den, dwe, di, daddr, smp_valid, smp_chan, smp_data, drop_cnt, timeout, busy} !== exp_v) begin
            n_bad++;
            $display("FAIL mid_reset_vals: got %h want %h",
                     {den, dwe, di, daddr, smp_valid, smp_chan, smp_data, drop_cnt, timeout, busy}, exp_v);
        end
        tick();
        resetn = 1'b1;
        tick();
        a0 = acc_cnt;
        man_do = 16'h5550; man_drdy = 1'b1;
        tick();
        man_drdy = 1'b0;
        tick();
        n_cmp++;
        if (smp_valid !== 1'b0 || acc_cnt !== a0) begin
            n_bad++; $display("FAIL mid_late_drdy: valid %b samples %0d want 0/0", smp_valid, acc_cnt - a0);
        end
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_late_busy: got %b want 0", busy); end
        rsp_en = 1'b1; rsp_data = 16'h2460;
        pulse_eoc();
        n_cmp++;
        if (daddr !== 7'h1E) begin n_bad++; $display("FAIL mid_next_addr: got %h want 1e", daddr); end
        wait_valid();
        n_cmp++;
        if (smp_chan !== 2'd0 || smp_data !== 12'h246) begin
            n_bad++; $display("FAIL mid_next_sample: got %0d/%h want 0/246", smp_chan, smp_data);
        end
        tick();
    endtask

    initial begin
        resetn = 1'b0; chan_en = 4'b0000; eoc = 1'b0; smp_ready = 1'b0;
        man_drdy = 1'b0; man_do = 16'h0000;
        test_reset();
        test_round_robin();
        test_mask();
        test_eoc_storm();
        test_drop();
        test_timeout();
        test_reset_midread();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
